apb_bridge_timeout: RTL and testbench
=====================================

Name: apb_bridge_timeout

Overview:
- Parametrised successor to the fixed APB1 segment bridge-plus-register-slice arrangement.
- One upstream APB completer port fans out to NUM_PORTS equal-sized downstream requester blocks.
- Downstream request and upstream response paths are each registered once, replacing the per-port register slices.
- Adds decode-error responses for unmapped addresses, a per-transaction timeout watchdog that aborts hung peripherals, and error/status capture for firmware.

Parameters:
- NUM_PORTS, 8, number of downstream blocks (1..32).
- BLOCK_SIZE, 32'h400, bytes per downstream block; power of two.
- UP_ADDR_WIDTH, 16, upstream paddr width.
- DATA_WIDTH, 32, data width; pstrb width = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, ACCESS cycles allowed before abort; 0 disables the watchdog.
- DN_ADDR_WIDTH, $clog2(BLOCK_SIZE), derived; downstream paddr width.

Ports:
- pclk  in  1  APB clock.
- preset  in  1  asynchronous reset, active-high.
- up_psel, up_penable, up_pwrite  in  1 each  upstream APB control.
- up_paddr  in  UP_ADDR_WIDTH  upstream address.
- up_pwdata  in  DATA_WIDTH  upstream write data.
- up_pstrb  in  DATA_WIDTH/8  upstream write strobes.
- up_pready  out  1  upstream ready.
- up_prdata  out  DATA_WIDTH  upstream read data.
- up_pslverr  out  1  upstream error.
- dn_psel  out  NUM_PORTS  one-hot downstream select.
- dn_penable, dn_pwrite  out  1 each  shared downstream control.
- dn_paddr  out  DN_ADDR_WIDTH  shared downstream address, equal to up_paddr[DN_ADDR_WIDTH-1:0].
- dn_pwdata  out  DATA_WIDTH  shared downstream write data.
- dn_pstrb  out  DATA_WIDTH/8  shared downstream strobes.
- dn_pready  in  NUM_PORTS  per-port ready.
- dn_prdata  in  NUM_PORTS*DATA_WIDTH  per-port read data; port i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- dn_pslverr  in  NUM_PORTS  per-port error.
- timeout_pulse  out  1  one-cycle strobe on each watchdog abort.
- timeout_count  out  16  saturating count of aborts.
- last_err_addr  out  UP_ADDR_WIDTH  upstream address of the most recent decode error or timeout.

Behaviour:
- Reset: all outputs 0; FSM enters IDLE; watchdog counter is 0.
- Decode: port = up_paddr >> DN_ADDR_WIDTH.
  - Port valid only if it is < NUM_PORTS and all higher address bits are 0.
  - Decoding happens in the upstream SETUP cycle (up_psel=1, up_penable=0), with address/data/control captured into registers at that cycle (call it T).
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Upstream SETUP with a valid port -> SETUP.
  - Upstream SETUP with an invalid port -> RESP with error flag set; no dn_psel is ever asserted.
- SETUP (cycle T+1): dn_psel[port]=1, dn_penable=0; go to ACCESS.
- ACCESS (from T+2):
  - dn_psel[port]=1 and dn_penable=1.
  - When dn_pready[port]=1: capture dn_prdata/dn_pslverr of that port, deassert dn_psel/dn_penable next cycle, go to RESP.
  - Else, if TIMEOUT_CYCLES≠0 and the watchdog reaches TIMEOUT_CYCLES-1: deassert dn_psel/dn_penable, set the error flag, prdata=0, go to RESP.
- RESP: up_pready=1 for exactly one cycle.
  - up_prdata = captured data (0 on writes and errors).
  - up_pslverr = captured pslverr or error flag.
  - Then return to IDLE; the flag and watchdog clear.
- Latency: valid access completes upstream 1 cycle after the downstream ready cycle. Minimum is up_pready at T+3; decode error gives up_pready at T+1.
- up_pready, up_prdata and up_pslverr are 0 in every cycle except RESP.
- Watchdog counter:
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - Counts only ACCESS cycles; resets on entry to ACCESS.
  - dn_pready arriving in the same cycle the count expires takes priority: normal completion, no abort.
- On abort:
  - timeout_pulse=1 in the RESP cycle.
  - timeout_count increments, saturating at 16'hFFFF.
  - last_err_addr is loaded.
  - A later dn_pready from the aborted port is ignored because its psel is low.
- Decode error: last_err_addr is loaded; timeout_count is unchanged.
- Downstream inputs from unselected ports are ignored at all times.
- Upstream SETUP seen while not in IDLE is a protocol violation by the requester; the bridge ignores it.
- dn_paddr/dn_pwdata/dn_pwrite/dn_pstrb are held constant from SETUP through ACCESS.
- Reset mid-transaction: everything returns to reset values immediately; the in-flight transfer is dropped with no response.

Test Plan:
- Read port 2 (up_paddr=16'h0804), peripheral returns 32'hCAFEF00D with zero wait states:
  - dn_psel=8'h04 at T+1, dn_penable at T+2, dn_paddr=10'h004.
  - up_pready at T+3 with prdata=32'hCAFEF00D, pslverr=0.
- Write port 7 (16'h1C10, pwdata 32'h12345678, pstrb 4'hF), port stalls 5 cycles, then pready with pslverr=1:
  - dn_pwdata stable throughout.
  - up_pready at ready+1 with pslverr=1.
- Access 16'h2000 (port 8, unmapped):
  - dn_psel stays 0.
  - up_pready at T+1 with pslverr=1, prdata=0.
  - last_err_addr=16'h2000; timeout_count unchanged.
- TIMEOUT_CYCLES=16, port 3 never ready:
  - Abort after 16 ACCESS cycles; up_pslverr=1, timeout_pulse high for 1 cycle.
  - timeout_count=1, last_err_addr=16'h0C00.
  - A late dn_pready[3] is ignored.
  - A following read of port 0 completes normally.
- TIMEOUT_CYCLES=16, dn_pready asserted exactly on the 16th ACCESS cycle: normal completion, no timeout_pulse, count unchanged.
- preset asserted during ACCESS:
  - All outputs 0 immediately.
  - After release, a fresh read of port 1 completes with correct data and latency T+3.

Source files
------------

// File: rtl/apb_bridge_timeout_if.sv
// Bus bundle for the APB fan-out bridge: upstream completer side plus shared/per-port downstream side.
// The bridge uses 'slave'; whatever drives the upstream requester and the downstream peripherals uses 'master'.
interface apb_bridge_timeout_if #(
  parameter int NUM_PORTS     = 8,
  parameter int UP_ADDR_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int DN_ADDR_WIDTH = 10
);
  logic                            up_psel;
  logic                            up_penable;
  logic                            up_pwrite;
  logic [UP_ADDR_WIDTH-1:0]        up_paddr;
  logic [DATA_WIDTH-1:0]           up_pwdata;
  logic [DATA_WIDTH/8-1:0]         up_pstrb;
  logic                            up_pready;
  logic [DATA_WIDTH-1:0]           up_prdata;
  logic                            up_pslverr;
  logic [NUM_PORTS-1:0]            dn_psel;
  logic                            dn_penable;
  logic                            dn_pwrite;
  logic [DN_ADDR_WIDTH-1:0]        dn_paddr;
  logic [DATA_WIDTH-1:0]           dn_pwdata;
  logic [DATA_WIDTH/8-1:0]         dn_pstrb;
  logic [NUM_PORTS-1:0]            dn_pready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] dn_prdata;
  logic [NUM_PORTS-1:0]            dn_pslverr;

  modport slave (
    input  up_psel, up_penable, up_pwrite, up_paddr, up_pwdata, up_pstrb,
    output up_pready, up_prdata, up_pslverr,
    output dn_psel, dn_penable, dn_pwrite, dn_paddr, dn_pwdata, dn_pstrb,
    input  dn_pready, dn_prdata, dn_pslverr
  );

  modport master (
    output up_psel, up_penable, up_pwrite, up_paddr, up_pwdata, up_pstrb,
    input  up_pready, up_prdata, up_pslverr,
    input  dn_psel, dn_penable, dn_pwrite, dn_paddr, dn_pwdata, dn_pstrb,
    output dn_pready, dn_prdata, dn_pslverr
  );
endinterface

// File: rtl/apb_bridge_timeout.sv
// APB bridge: one upstream completer fanned out to NUM_PORTS equal blocks, with decode-error
// responses, a per-transaction ACCESS watchdog, and abort/error status for firmware.
module apb_bridge_timeout #(
  parameter int          NUM_PORTS      = 8,
  parameter logic [31:0] BLOCK_SIZE     = 32'h400,
  parameter int          UP_ADDR_WIDTH  = 16,
  parameter int          DATA_WIDTH     = 32,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          DN_ADDR_WIDTH  = $clog2(BLOCK_SIZE)
) (
  input  logic                     pclk,
  input  logic                     preset,
  apb_bridge_timeout_if.slave      bus,
  output logic                     timeout_pulse,
  output logic [15:0]              timeout_count,
  output logic [UP_ADDR_WIDTH-1:0] last_err_addr
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int WD_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                   state_q, state_d;
  logic [PORT_W-1:0]        port_q;
  logic [UP_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q, rdata_q;
  logic [STRB_W-1:0]        strb_q;
  logic                     write_q, err_q, tmo_q;
  logic [WD_W-1:0]          wd_q;

  // Port index is the address shifted down by the block size; anything at or above NUM_PORTS,
  // including addresses with stray high bits, is unmapped.
  logic [UP_ADDR_WIDTH-1:0] port_full;
  logic                     port_valid, up_setup, sel_ready, sel_err, tmo_hit;
  logic [DATA_WIDTH-1:0]    sel_data;

  assign port_full  = bus.up_paddr >> DN_ADDR_WIDTH;
  assign port_valid = port_full < UP_ADDR_WIDTH'(NUM_PORTS);
  assign up_setup   = bus.up_psel && !bus.up_penable;
  assign sel_ready  = bus.dn_pready[port_q];
  assign sel_err    = bus.dn_pslverr[port_q];
  assign sel_data   = bus.dn_prdata[port_q*DATA_WIDTH +: DATA_WIDTH];
  assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (up_setup) state_d = port_valid ? SETUP : RESP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (sel_ready || tmo_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= IDLE;
      port_q        <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      strb_q        <= '0;
      write_q       <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      tmo_q         <= 1'b0;
      wd_q          <= '0;
      timeout_count <= '0;
      last_err_addr <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (up_setup) begin
          addr_q  <= bus.up_paddr;
          wdata_q <= bus.up_pwdata;
          strb_q  <= bus.up_pstrb;
          write_q <= bus.up_pwrite;
          port_q  <= port_full[PORT_W-1:0];
          rdata_q <= '0;
          err_q   <= !port_valid;
          tmo_q   <= 1'b0;
          if (!port_valid) last_err_addr <= bus.up_paddr;
        end
        SETUP: wd_q <= '0;
        ACCESS: begin
          // A ready arriving on the expiry cycle wins over the abort.
          if (sel_ready) begin
            rdata_q <= (write_q || sel_err) ? '0 : sel_data;
            err_q   <= sel_err;
          end else if (tmo_hit) begin
            err_q         <= 1'b1;
            tmo_q         <= 1'b1;
            last_err_addr <= addr_q;
            if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        RESP: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          tmo_q   <= 1'b0;
          wd_q    <= '0;
        end
        default: ;
      endcase
    end
  end

  logic in_resp, dn_active;
  assign in_resp   = (state_q == RESP);
  assign dn_active = (state_q == SETUP) || (state_q == ACCESS);

  assign bus.up_pready  = in_resp;
  assign bus.up_prdata  = in_resp ? rdata_q : '0;
  assign bus.up_pslverr = in_resp && err_q;
  assign timeout_pulse  = in_resp && tmo_q;

  assign bus.dn_psel    = dn_active ? (NUM_PORTS'(1) << port_q) : '0;
  assign bus.dn_penable = (state_q == ACCESS);
  assign bus.dn_pwrite  = write_q;
  assign bus.dn_paddr   = addr_q[DN_ADDR_WIDTH-1:0];
  assign bus.dn_pwdata  = wdata_q;
  assign bus.dn_pstrb   = strb_q;
endmodule

// File: tb/tb_apb_bridge_timeout.sv
// Randomized bench for apb_bridge_timeout: a transaction-level model predicts every output on every
// cycle from the transaction's start cycle, target port and planned wait count.
module tb_apb_bridge_timeout;
  localparam int NP = 8, AW = 16, DW = 32, DAW = 10, TO = 16;

  logic pclk = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  apb_bridge_timeout_if #(.NUM_PORTS(NP), .UP_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DN_ADDR_WIDTH(DAW)) bus ();
  logic          timeout_pulse;
  logic [15:0]   timeout_count;
  logic [AW-1:0] last_err_addr;

  apb_bridge_timeout #(.NUM_PORTS(NP), .BLOCK_SIZE(32'h400), .UP_ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset(preset), .bus(bus),
    .timeout_pulse(timeout_pulse), .timeout_count(timeout_count), .last_err_addr(last_err_addr));

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Current transaction as the model sees it.
  bit            m_act = 0, m_valid = 0, m_wr = 0, m_err = 0;
  int            m_T = 0, m_W = 0, m_port = 0;
  logic [DW-1:0] m_data = '0, m_wdata = '0;
  logic [3:0]    m_strb = '0;
  logic [AW-1:0] m_addr = '0;
  int            exp_count = 0;
  logic [AW-1:0] exp_last = '0;

  function automatic bit m_to();
    return m_valid && (m_W >= TO);
  endfunction

  // Cycle in which the upstream response appears.
  function automatic int resp_cyc();
    if (!m_valid) return m_T + 1;
    if (m_W >= TO) return m_T + TO + 2;
    return m_T + 3 + m_W;
  endfunction

  always @(negedge pclk) begin : cmp
    int r;
    logic [NP-1:0] e_psel;
    bit e_pen, e_rdy, e_err, e_pulse;
    logic [DW-1:0] e_rd;
    e_psel = '0; e_pen = 0; e_rdy = 0; e_err = 0; e_pulse = 0; e_rd = '0;
    if (m_act && !preset) begin
      r = resp_cyc();
      if (m_valid && cyc >= m_T + 1 && cyc < r) e_psel = NP'(1) << m_port;
      e_pen = m_valid && cyc >= m_T + 2 && cyc < r;
      if (cyc == r) begin
        e_rdy   = 1;
        e_err   = !m_valid || m_to() || m_err;
        e_rd    = (e_err || m_wr) ? '0 : m_data;
        e_pulse = m_to();
        if (m_to() && exp_count < 16'hFFFF) exp_count++;
        if (!m_valid || m_to()) exp_last = m_addr;
      end
    end
    chk("dn_psel", bus.dn_psel, e_psel);
    chk("dn_penable", bus.dn_penable, e_pen);
    chk("up_pready", bus.up_pready, e_rdy);
    chk("up_pslverr", bus.up_pslverr, e_err);
    chk("up_prdata", bus.up_prdata, e_rd);
    chk("timeout_pulse", timeout_pulse, e_pulse);
    chk("timeout_count", timeout_count, exp_count);
    chk("last_err_addr", last_err_addr, exp_last);
    if (e_psel != '0) begin
      chk("dn_paddr", bus.dn_paddr, m_addr[DAW-1:0]);
      chk("dn_pwdata", bus.dn_pwdata, m_wdata);
      chk("dn_pwrite", bus.dn_pwrite, m_wr);
      chk("dn_pstrb", bus.dn_pstrb, m_strb);
    end
  end

  // Peripherals: junk everywhere except the target port inside its ACCESS window.
  always @(posedge pclk) begin : rsp
    logic [NP-1:0] rdy, serr;
    logic [NP*DW-1:0] rd;
    int r;
    #2;
    for (int i = 0; i < NP; i++) begin
      rdy[i] = 1'($urandom_range(0, 1));
      serr[i] = 1'($urandom_range(0, 1));
      rd[i*DW +: DW] = $urandom;
    end
    if (m_act && m_valid && !preset) begin
      r = resp_cyc();
      if (cyc >= m_T + 2 && cyc < r) rdy[m_port] = (cyc == m_T + 2 + m_W);
      rd[m_port*DW +: DW] = m_data;
      serr[m_port] = m_err;
    end
    bus.dn_pready = rdy;
    bus.dn_pslverr = serr;
    bus.dn_prdata = rd;
  end

  task automatic start_setup(input logic [AW-1:0] a, input bit wr, input logic [DW-1:0] wd,
                             input logic [3:0] st, input int w, input logic [DW-1:0] d, input bit e);
    @(posedge pclk); #1;
    bus.up_psel = 1; bus.up_penable = 0; bus.up_paddr = a;
    bus.up_pwrite = wr; bus.up_pwdata = wd; bus.up_pstrb = st;
    m_act = 1; m_T = cyc; m_W = w; m_valid = (int'(a) >> DAW) < NP; m_port = int'(a) >> DAW;
    m_wr = wr; m_wdata = wd; m_strb = st; m_data = d; m_err = e; m_addr = a;
    @(posedge pclk); #1;
    bus.up_penable = 1;
  endtask

  task automatic txn(input logic [AW-1:0] a, input bit wr, input logic [DW-1:0] wd, input logic [3:0] st,
                     input int w, input logic [DW-1:0] d, input bit e,
                     output int lat, output logic [DW-1:0] rd, output bit re);
    start_setup(a, wr, wd, st, w, d, e);
    lat = -1; rd = '0; re = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge pclk);
      if (bus.up_pready) begin
        lat = cyc - m_T; rd = bus.up_prdata; re = bus.up_pslverr;
        break;
      end
    end
    if (lat < 0) begin
      n_vec++; n_err++;
      $display("FAIL handshake: no up_pready within 60 cycles of addr %0h", a);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
      bus.up_psel = 0; bus.up_penable = 0;
    end
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench hung");
  end

  initial begin : main
    int lat;
    logic [DW-1:0] rd;
    bit re;
    logic [31:0] rv;
    logic [AW-1:0] a;
    int p, w;
    bus.up_psel = 0; bus.up_penable = 0; bus.up_pwrite = 0;
    bus.up_paddr = '0; bus.up_pwdata = '0; bus.up_pstrb = '0;
    bus.dn_pready = '0; bus.dn_prdata = '0; bus.dn_pslverr = '0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_up_pready", bus.up_pready, 0);
    chk("rst_dn_psel", bus.dn_psel, 0);
    chk("rst_timeout_count", timeout_count, 0);
    @(posedge pclk); #1 preset = 0;
    idle(2);

    txn(16'h0804, 0, 32'h0, 4'h0, 0, 32'hCAFEF00D, 0, lat, rd, re);
    chk("p2_read_lat", lat, 3);
    chk("p2_read_data", rd, 32'hCAFEF00D);
    chk("p2_read_err", re, 0);
    idle(1);

    txn(16'h1C10, 1, 32'h12345678, 4'hF, 5, 32'hDEADDEAD, 1, lat, rd, re);
    chk("p7_write_lat", lat, 8);
    chk("p7_write_err", re, 1);
    chk("p7_write_data", rd, 0);
    idle(1);

    txn(16'h2000, 0, 32'h0, 4'h0, 0, 32'h0, 0, lat, rd, re);
    chk("decerr_lat", lat, 1);
    chk("decerr_err", re, 1);
    chk("decerr_last", last_err_addr, 16'h2000);
    chk("decerr_count", timeout_count, 0);
    idle(1);

    txn(16'h0C00, 0, 32'h0, 4'h0, 1000, 32'h55AA55AA, 0, lat, rd, re);
    chk("tmo_lat", lat, 18);
    chk("tmo_err", re, 1);
    chk("tmo_pulse", timeout_pulse, 1);
    chk("tmo_count", timeout_count, 1);
    chk("tmo_last", last_err_addr, 16'h0C00);
    idle(4);

    txn(16'h0010, 0, 32'h0, 4'h0, 2, 32'h0BADBEEF, 0, lat, rd, re);
    chk("p0_after_tmo_lat", lat, 5);
    chk("p0_after_tmo_data", rd, 32'h0BADBEEF);
    idle(1);

    txn(16'h1400, 0, 32'h0, 4'h0, 15, 32'hA5A5A5A5, 0, lat, rd, re);
    chk("edge_ready_lat", lat, 18);
    chk("edge_ready_err", re, 0);
    chk("edge_ready_pulse", timeout_pulse, 0);
    chk("edge_ready_count", timeout_count, 1);
    idle(1);

    // Reset in the middle of an ACCESS phase.
    start_setup(16'h1008, 0, 32'h0, 4'h0, 50, 32'h77777777, 0);
    repeat (3) @(posedge pclk);
    #1;
    preset = 1; m_act = 0; exp_count = 0; exp_last = '0;
    bus.up_psel = 0; bus.up_penable = 0;
    @(negedge pclk);
    chk("midrst_dn_psel", bus.dn_psel, 0);
    chk("midrst_dn_penable", bus.dn_penable, 0);
    chk("midrst_count", timeout_count, 0);
    chk("midrst_last", last_err_addr, 0);
    @(posedge pclk); #1 preset = 0;
    idle(1);
    txn(16'h0420, 0, 32'h0, 4'h0, 0, 32'h11112222, 0, lat, rd, re);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_data", rd, 32'h11112222);
    idle(1);

    for (int n = 0; n < 250; n++) begin
      rv = $urandom;
      p = $urandom_range(0, 9);
      if (p < NP) a = AW'(p * 32'h400) | {6'd0, rv[9:2], 2'b00};
      else a = rv[15:0] | 16'h2000;
      case ($urandom_range(0, 5))
        0: w = 0;
        1: w = 1;
        2: w = $urandom_range(0, 6);
        3: w = TO - 1;
        4: w = TO;
        default: w = $urandom_range(0, 25);
      endcase
      rv = $urandom;
      txn(a, bit'($urandom_range(0, 1)), rv, 4'($urandom_range(0, 15)), w, $urandom,
          bit'($urandom_range(0, 3) == 0), lat, rd, re);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
